vm_stubs_binned: RTL

- Parametrised next-generation virtual-module stub buffer.
- Accepts a stream of stubs and filters them on a bend/range field.
- Sorts accepted stubs into 2^BIN_BITS sub-bins, each with its own fill counter, inside a ring of 2^PAGE_BITS bunch-crossing pages.
- Downstream engines read stubs and per-(page,bin) entry counts through one random-access port; per-bin overflow is flagged instead of wrapping.

---
 rtl/vm_stubs_binned_if.sv | 30 +++
 rtl/vm_stubs_binned.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vm_stubs_binned_if.sv
// Stub buffer bus: write stream, control strobes and random-access read port.
// The master drives stubs, start and read_add; the slave (buffer) returns the rest.
interface vm_stubs_binned_if #(
    parameter int DATA_WIDTH = 19,
    parameter int ADDR_BITS  = 4,
    parameter int BIN_BITS   = 3,
    parameter int PAGE_BITS  = 1
);
    localparam int RA_W = PAGE_BITS + BIN_BITS + ADDR_BITS;

    logic [1:0]            start;
    logic [1:0]            done;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  enable;
    logic [RA_W-1:0]       read_add;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ADDR_BITS:0]    number_out;
    logic                  overflow_out;
    logic [PAGE_BITS-1:0]  wr_page;

    modport master (
        output start, data_in, enable, read_add,
        input  done, data_out, number_out, overflow_out, wr_page
    );

    modport slave (
        input  start, data_in, enable, read_add,
        output done, data_out, number_out, overflow_out, wr_page
    );
endinterface

// File: rtl/vm_stubs_binned.sv
// Binned virtual-module stub buffer: filters stubs, sorts them into bins
// inside a ring of BX pages, and serves data/counts on one read port.
module vm_stubs_binned #(
    parameter int DATA_WIDTH = 19,
    parameter int ADDR_BITS  = 4,
    parameter int BIN_BITS   = 3,
    parameter int PAGE_BITS  = 1,
    parameter int BIN_LSB    = 16,
    parameter int FILT_LSB   = 10,
    parameter int FILT_W     = 6,
    parameter int FILT_MAX   = 31,
    parameter int DONE_DELAY = 5
) (
    input logic           clk,
    input logic           reset,
    vm_stubs_binned_if.slave vm
);
    localparam int SW   = PAGE_BITS + BIN_BITS;
    localparam int AW   = SW + ADDR_BITS;
    localparam int NPB  = 1 << SW;
    localparam int NMEM = 1 << AW;
    localparam int CW   = ADDR_BITS + 1;

    localparam logic [CW-1:0]   FULL = CW'(1 << ADDR_BITS);
    localparam logic [FILT_W:0] FMAX = (FILT_W + 1)'(FILT_MAX);

    logic [1:0]            r_start_q;
    logic [PAGE_BITS-1:0]  r_wr_page;
    logic [1:0]            r_done_pipe [DONE_DELAY];
    logic [CW-1:0]         r_cnt [NPB];
    logic [NPB-1:0]        r_ovf;

    logic                  r_wr_en;
    logic [AW-1:0]         r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_mem [NMEM];

    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [CW-1:0]         r_rd_cnt;
    logic                  r_rd_ovf;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [CW-1:0]         r_number_out;
    logic                  r_overflow_out;

    logic [FILT_W-1:0]     w_filt;
    logic [BIN_BITS-1:0]   w_bin;
    logic                  w_new;
    logic [PAGE_BITS-1:0]  w_page;
    logic [SW-1:0]         w_slot;
    logic [CW-1:0]         w_cur;
    logic                  w_acc;
    logic                  w_full;
    logic                  w_wr;
    logic [SW-1:0]         w_rd_slot;

    assign w_filt = vm.data_in[FILT_LSB +: FILT_W];
    assign w_bin  = vm.data_in[BIN_LSB +: BIN_BITS];

    // A new page is opened this cycle; a same-cycle stub lands in it at entry 0.
    assign w_new  = r_start_q[0] & ~r_start_q[1];
    assign w_page = w_new ? r_wr_page + PAGE_BITS'(1) : r_wr_page;
    assign w_slot = {w_page, w_bin};
    assign w_cur  = w_new ? '0 : r_cnt[w_slot];

    assign w_acc  = vm.enable & ({1'b0, w_filt} < FMAX) & ~r_start_q[1];
    assign w_full = (w_cur == FULL);
    assign w_wr   = w_acc & ~w_full;

    assign w_rd_slot = vm.read_add[AW-1:ADDR_BITS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_q <= '0;
            r_wr_page <= '1;
            for (int i = 0; i < DONE_DELAY; i++) begin
                r_done_pipe[i] <= '0;
            end
        end else begin
            r_start_q      <= vm.start;
            r_done_pipe[0] <= vm.start;
            for (int i = 1; i < DONE_DELAY; i++) begin
                r_done_pipe[i] <= r_done_pipe[i-1];
            end
            if (r_start_q[1]) begin
                r_wr_page <= '1;
            end else if (r_start_q[0]) begin
                r_wr_page <= w_page;
            end
        end
    end

    // Per-(page,bin) fill counters saturate at FULL and raise a sticky flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPB; i++) begin
                r_cnt[i] <= '0;
            end
            r_ovf <= '0;
        end else begin
            if (w_new) begin
                for (int b = 0; b < (1 << BIN_BITS); b++) begin
                    r_cnt[{w_page, BIN_BITS'(b)}] <= '0;
                    r_ovf[{w_page, BIN_BITS'(b)}] <= 1'b0;
                end
            end
            if (w_wr) begin
                r_cnt[w_slot] <= w_cur + CW'(1);
            end
            if (w_acc && w_full) begin
                r_ovf[w_slot] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= w_wr;
            r_wr_addr <= {w_slot, w_cur[ADDR_BITS-1:0]};
            r_wr_data <= vm.data_in;
        end
    end

    // Simple dual-port RAM with registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (r_wr_en) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
        r_rd_data <= r_mem[vm.read_add];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_cnt       <= '0;
            r_rd_ovf       <= 1'b0;
            r_data_out     <= '0;
            r_number_out   <= '0;
            r_overflow_out <= 1'b0;
        end else begin
            r_rd_cnt       <= r_cnt[w_rd_slot];
            r_rd_ovf       <= r_ovf[w_rd_slot];
            r_data_out     <= r_rd_data;
            r_number_out   <= r_rd_cnt;
            r_overflow_out <= r_rd_ovf;
        end
    end

    assign vm.done         = r_done_pipe[DONE_DELAY-1];
    assign vm.wr_page      = r_wr_page;
    assign vm.data_out     = r_data_out;
    assign vm.number_out   = r_number_out;
    assign vm.overflow_out = r_overflow_out;
endmodule
